// File: rtl/cheri_dmem_sram_bridge.sv
// Bridges the core data port and the TS-map read port onto one single-port SRAM.
// The TS-map port always wins; data responses come back through one registered stage.
module cheri_dmem_sram_bridge #(
    parameter logic [31:0] MemBase   = 32'h200f_0000,
    parameter int unsigned MemAddrW  = 14,
    parameter int unsigned DataWidth = 33
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,

    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    input  logic                 data_we_i,
    input  logic                 data_is_cap_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_err_o,

    input  logic                 tsmap_cs_i,
    input  logic [15:0]          tsmap_addr_i,
    output logic [DataWidth-1:0] tsmap_rdata_o,

    output logic                 sram_cs_o,
    output logic                 sram_we_o,
    output logic [3:0]           sram_be_o,
    output logic                 sram_tag_we_o,
    output logic [MemAddrW-1:0]  sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    input  logic [DataWidth-1:0] sram_rdata_i,

    output logic [15:0]          stall_cnt_o
);

    localparam logic [32:0] WinBytes = 33'd4 << MemAddrW;

    logic [31:0] offset;
    logic        in_range, cap_bad, legal, gnt, cs_raw;

    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_we_q,  rsp_we_d;
    logic        ts_vld_q,  ts_vld_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic unused_tsmap_hi;
    assign unused_tsmap_hi = ^tsmap_addr_i[15:MemAddrW];

    // offset wraps for addresses below the window, so the lower bound is checked separately
    assign offset   = data_addr_i - MemBase;
    assign in_range = (data_addr_i >= MemBase) && ({1'b0, offset} < WinBytes);
    assign cap_bad  = data_is_cap_i && ((data_be_i != 4'hF) || (data_addr_i[1:0] != 2'b00));
    assign legal    = in_range && !cap_bad;
    assign gnt      = data_req_i & ~tsmap_cs_i;

    assign data_gnt_o = gnt;

    always_comb begin
        cs_raw        = 1'b0;
        sram_we_o     = 1'b0;
        sram_be_o     = 4'h0;
        sram_tag_we_o = 1'b0;
        sram_addr_o   = '0;
        sram_wdata_o  = '0;
        if (tsmap_cs_i) begin
            cs_raw      = 1'b1;
            sram_addr_o = tsmap_addr_i[MemAddrW-1:0];
        end else if (gnt && legal) begin
            cs_raw      = 1'b1;
            sram_we_o   = data_we_i;
            sram_be_o   = data_be_i;
            sram_addr_o = offset[MemAddrW+1:2];
            if (data_we_i) begin
                // plain data stores always clear the capability tag
                sram_tag_we_o              = 1'b1;
                sram_wdata_o[31:0]         = data_wdata_i[31:0];
                sram_wdata_o[DataWidth-1]  = data_is_cap_i & data_wdata_i[DataWidth-1];
            end
        end
    end

    assign sram_cs_o = cs_raw & rstn_i;

    always_comb begin
        rsp_vld_d   = gnt;
        rsp_err_d   = gnt & ~legal;
        rsp_we_d    = gnt & data_we_i;
        ts_vld_d    = tsmap_cs_i;
        stall_cnt_d = stall_cnt_q;
        if (data_req_i && tsmap_cs_i && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
            ts_vld_q    <= 1'b0;
            stall_cnt_q <= 16'h0;
        end else begin
            rsp_vld_q   <= rsp_vld_d;
            rsp_err_q   <= rsp_err_d;
            rsp_we_q    <= rsp_we_d;
            ts_vld_q    <= ts_vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign data_rvalid_o = rsp_vld_q;
    assign data_err_o    = rsp_vld_q & rsp_err_q;
    assign data_rdata_o  = (rsp_vld_q && !rsp_err_q && !rsp_we_q) ? sram_rdata_i : '0;
    assign tsmap_rdata_o = ts_vld_q ? sram_rdata_i : '0;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_cheri_dmem_sram_bridge.sv
// Random and directed stimulus for the dmem/SRAM bridge, checked against a shadow memory model.
module tb_cheri_dmem_sram_bridge;

    localparam longint BASE  = 64'h200f_0000;
    localparam int     DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_is_cap_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [32:0] data_wdata_i, data_rdata_o;
    logic        data_err_o;
    logic        tsmap_cs_i;
    logic [15:0] tsmap_addr_i;
    logic [32:0] tsmap_rdata_o;
    logic        sram_cs_o, sram_we_o, sram_tag_we_o;
    logic [3:0]  sram_be_o;
    logic [13:0] sram_addr_o;
    logic [32:0] sram_wdata_o, sram_rdata_i;
    logic [15:0] stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    int stall_exp = 0;

    logic [32:0] sram_mem [DEPTH];
    logic [32:0] ref_mem  [DEPTH];

    always #5 clk = ~clk;

    cheri_dmem_sram_bridge dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_is_cap_i(data_is_cap_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .tsmap_cs_i(tsmap_cs_i), .tsmap_addr_i(tsmap_addr_i), .tsmap_rdata_o(tsmap_rdata_o),
        .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o),
        .sram_tag_we_o(sram_tag_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .stall_cnt_o(stall_cnt_o)
    );

    // SRAM environment: reads return data one cycle after cs
    always @(posedge clk) begin
        if (sram_cs_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
                if (sram_tag_we_o) sram_mem[sram_addr_o][32] <= sram_wdata_o[32];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [31:0] a, input bit cap, input logic [3:0] b);
        longint la;
        bit inr;
        la  = longint'(a);
        inr = (la >= BASE) && (la < BASE + 4 * DEPTH);
        return inr && !(cap && ((b != 4'hF) || (a[1:0] != 2'b00)));
    endfunction

    // One clock: inputs already driven; check combinational side mid-cycle, then the registered side.
    task automatic cycle();
        bit          g, leg, nv, nerr;
        int          idx, tsi;
        logic [32:0] nrd, nts, wexp;
        #4;
        g   = data_req_i && !tsmap_cs_i;
        leg = ref_legal(data_addr_i, data_is_cap_i, data_be_i);
        idx = leg ? int'((longint'(data_addr_i) - BASE) / 4) : 0;
        tsi = int'(tsmap_addr_i % DEPTH);
        chk("gnt", data_gnt_o, g);
        chk("sram_cs", sram_cs_o, rstn_i && (tsmap_cs_i || (g && leg)));
        if (tsmap_cs_i) begin
            chk("ts_addr", sram_addr_o, tsi);
            chk("ts_we", sram_we_o, 0);
        end else if (g && leg) begin
            chk("addr", sram_addr_o, idx);
            chk("we", sram_we_o, data_we_i);
            chk("be", sram_be_o, data_be_i);
            chk("tag_we", sram_tag_we_o, data_we_i);
            if (data_we_i) begin
                wexp = {data_is_cap_i ? data_wdata_i[32] : 1'b0, data_wdata_i[31:0]};
                chk("wdata", sram_wdata_o, wexp);
            end
        end else if (!g) begin
            chk("idle_bus", {sram_we_o, sram_tag_we_o, sram_be_o, sram_addr_o, sram_wdata_o}, 0);
        end
        if (!rstn_i) begin
            chk("rst_rvalid", data_rvalid_o, 0);
            chk("rst_err", data_err_o, 0);
            chk("rst_rdata", data_rdata_o, 0);
            chk("rst_tsdata", tsmap_rdata_o, 0);
            chk("rst_stall", stall_cnt_o, 0);
        end
        nv   = rstn_i && g;
        nerr = nv && !leg;
        nrd  = (nv && leg && !data_we_i) ? ref_mem[idx] : 33'h0;
        nts  = (rstn_i && tsmap_cs_i) ? ref_mem[tsi] : 33'h0;
        if (!rstn_i) stall_exp = 0;
        else if (data_req_i && tsmap_cs_i && stall_exp < 16'hFFFF) stall_exp++;
        if (rstn_i && g && leg && data_we_i) begin
            for (int b = 0; b < 4; b++)
                if (data_be_i[b]) ref_mem[idx][8*b +: 8] = data_wdata_i[8*b +: 8];
            ref_mem[idx][32] = data_is_cap_i ? data_wdata_i[32] : 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rvalid", data_rvalid_o, nv);
        chk("err", data_err_o, nerr);
        chk("rdata", data_rdata_o, nrd);
        chk("ts_rdata", tsmap_rdata_o, nts);
        chk("stall", stall_cnt_o, stall_exp);
    endtask

    task automatic drive(input bit req, input bit we, input bit cap, input logic [3:0] be,
                         input logic [31:0] a, input logic [32:0] wd, input bit ts, input logic [15:0] ta);
        data_req_i = req; data_we_i = we; data_is_cap_i = cap; data_be_i = be;
        data_addr_i = a; data_wdata_i = wd; tsmap_cs_i = ts; tsmap_addr_i = ta;
    endtask

    task automatic rand_req();
        logic [31:0] a;
        bit          cap;
        logic [3:0]  be;
        case ($urandom_range(0, 10))
            0, 1, 2, 3, 4, 5, 6: a = 32'(BASE + 4 * $urandom_range(0, 63));
            7:  a = 32'(BASE + $urandom_range(0, 255));
            8:  a = 32'(BASE - 4 * $urandom_range(1, 4));
            9:  a = 32'(BASE + 4 * DEPTH - 4 + 4 * $urandom_range(0, 2));
            default: a = $urandom;
        endcase
        cap = ($urandom_range(0, 3) == 0);
        be  = (cap && $urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, cap, be, a,
              {1'($urandom_range(0, 1)), 32'($urandom)}, $urandom_range(0, 99) < 15,
              16'($urandom_range(0, 65535)));
    endtask

    initial begin
        int n1;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = {1'($urandom_range(0, 1)), 32'($urandom)};
            sram_mem[i] = ref_mem[i];
        end
        sram_rdata_i = 33'h0;
        rstn_i = 1'b0;
        drive(0, 0, 0, 4'h0, 32'h0, 33'h0, 0, 16'h0);
        @(posedge clk); #1;
        cycle();
        cycle();
        rstn_i = 1'b1;

        ref_mem[4] = 33'h1_DEAD_BEEF; sram_mem[4] = 33'h1_DEAD_BEEF;
        drive(1, 0, 0, 4'hF, 32'h200f_0010, 33'h0, 0, 16'h0); cycle();
        drive(1, 1, 0, 4'h3, 32'h200f_0008, 33'h1_0000_1234, 0, 16'h0); cycle();
        drive(1, 0, 0, 4'hF, 32'h200f_0008, 33'h0, 0, 16'h0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 4'hF, 32'h200f_0010, 33'h0, 1, 16'd7); cycle();
        end
        chk("stall3", stall_cnt_o, 3);
        drive(1, 0, 0, 4'hF, 32'h200f_0010, 33'h0, 0, 16'd7); cycle();
        drive(1, 0, 0, 4'hF, 32'h2010_0000, 33'h0, 0, 16'h0); cycle();
        drive(1, 1, 1, 4'h7, 32'h200f_0020, 33'h1_1111_2222, 0, 16'h0); cycle();
        drive(1, 1, 1, 4'hF, 32'h200f_0022, 33'h1_1111_2222, 0, 16'h0); cycle();
        drive(1, 1, 1, 4'hF, 32'h200f_0024, 33'h1_3333_4444, 0, 16'h0); cycle();
        drive(1, 0, 1, 4'hF, 32'h200f_0024, 33'h0, 0, 16'h0); cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 4'hF, 32'h200f_0000 + 32'(4 * i), 33'h0, 0, 16'h0); cycle();
        end
        drive(1, 0, 0, 4'hF, 32'h200f_0000, 33'h0, 0, 16'h0); cycle();
        drive(1, 0, 0, 4'hF, 32'h200f_0004, 33'h0, 0, 16'h0); cycle();
        rstn_i = 1'b0;
        drive(1, 0, 0, 4'hF, 32'h200f_0008, 33'h0, 0, 16'h0); cycle();
        rstn_i = 1'b1;
        drive(0, 0, 0, 4'h0, 32'h0, 33'h0, 0, 16'h0); cycle(); cycle();

        for (int i = 0; i < 1500; i++) begin
            rand_req();
            cycle();
        end

        drive(1, 0, 0, 4'hF, 32'h200f_0000, 33'h0, 1, 16'd9);
        cycle();
        n1 = 65534 - stall_exp;
        repeat (n1) @(posedge clk);
        #1;
        stall_exp = 65534;
        chk("stall_fffe", stall_cnt_o, 16'hFFFE);
        for (int i = 0; i < 3; i++) cycle();
        repeat (70000 - n1 - 4) @(posedge clk);
        #1;
        chk("stall_sat", stall_cnt_o, 16'hFFFF);
        chk("ts_hold", tsmap_rdata_o, ref_mem[9]);
        drive(0, 0, 0, 4'h0, 32'h0, 33'h0, 0, 16'h0); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cheri_dmem_sram_bridge.md
CHERI_DMEM_SRAM_BRIDGE -- requirements
Module: cheri_dmem_sram_bridge

Interface
REQ-001 Param MemBase, 32'h200f_0000, byte base address of the SRAM window.
REQ-002 Param MemAddrW, 14, SRAM word-address width; window size is 4*2^MemAddrW bytes.
REQ-003 Param DataWidth, 33, data width; bit 32 is the capability tag.
REQ-004 clk_i  in  1  single clock; all state on its rising edge.
REQ-005 rstn_i  in  1  asynchronous active-low reset.
REQ-006 data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1 each  core data request handshake.
REQ-007 data_we_i  in  1; data_is_cap_i  in  1; data_be_i  in  4; data_addr_i  in  32; data_wdata_i  in  DataWidth  core request fields.
REQ-008 data_rdata_o  out  DataWidth; data_err_o  out  1  core response fields.
REQ-009 tsmap_cs_i  in  1; tsmap_addr_i  in  16; tsmap_rdata_o  out  DataWidth  TS-map read port, no handshake.
REQ-010 sram_cs_o  out  1; sram_we_o  out  1; sram_be_o  out  4; sram_tag_we_o  out  1; sram_addr_o  out  MemAddrW; sram_wdata_o  out  DataWidth  single-port SRAM request.
REQ-011 sram_rdata_i  in  DataWidth  SRAM read data, valid exactly one cycle after a read cs.
REQ-012 stall_cnt_o  out  16  saturating count of cycles data_req_i was denied.

Function
REQ-013 Arbitration per cycle: tsmap_cs_i has absolute priority; data_gnt_o = data_req_i & ~tsmap_cs_i (combinational).
REQ-014 TS-map access drives sram_cs_o=1, sram_we_o=0, sram_addr_o=tsmap_addr_i[MemAddrW-1:0]; tsmap_rdata_o = sram_rdata_i the following cycle, else 0.
REQ-015 Granted data request is in-range iff MemBase <= data_addr_i < MemBase + 4*2^MemAddrW; sram_addr_o = (data_addr_i - MemBase) >> 2.
REQ-016 Granted request is illegal if out of range, or data_is_cap_i=1 with data_be_i != 4'hF, or data_addr_i[1:0] != 0 with data_is_cap_i=1.
REQ-017 Legal granted request drives sram_cs_o=1, sram_we_o=data_we_i, sram_be_o=data_be_i; illegal request drives sram_cs_o=0.
REQ-018 Writes: sram_tag_we_o=1 for every legal write; written tag = data_is_cap_i ? data_wdata_i[32] : 0 (any data write clears the tag); bits 31:0 = data_wdata_i[31:0].
REQ-019 Response pipeline: one registered stage (valid, err, we); data_rvalid_o asserts exactly one cycle after each grant, one response per grant, in order.
REQ-020 Response data: legal read -> data_rdata_o = sram_rdata_i; write or illegal -> data_rdata_o = 0; data_err_o = 1 only for illegal, and only while data_rvalid_o=1.
REQ-021 Back-to-back grants on consecutive cycles are supported at full throughput (one response per cycle).
REQ-022 stall_cnt_o increments by 1 each cycle data_req_i=1 and tsmap_cs_i=1; saturates at 16'hFFFF; never wraps.
REQ-023 When idle (no grant, no tsmap_cs_i): sram_cs_o=0, sram_we_o=0, sram_tag_we_o=0, sram_be_o=0, sram_addr_o=0, sram_wdata_o=0.

Reset
REQ-024 On rstn_i=0: response-stage valid/err/we cleared, stall_cnt_o=0, tsmap_rdata_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0.
REQ-025 Reset asserted mid-transaction discards the pending response; no data_rvalid_o after reset release for a pre-reset grant.
REQ-026 data_gnt_o and SRAM outputs are combinational and follow REQ-013..REQ-023 irrespective of reset state, except sram_cs_o shall be 0 while rstn_i=0.

Verification
REQ-027 Read 0x200f_0010, SRAM word 4 = 33'h1_DEAD_BEEF -> gnt same cycle, sram_addr_o=4, next cycle rvalid=1, rdata=33'h1_DEAD_BEEF, err=0.
REQ-028 Word write be=4'h3 data=0x1234 is_cap=0 to 0x200f_0008 -> sram_cs/we=1, be=4'h3, tag_we=1, tag=0; next cycle rvalid=1, rdata=0, err=0.
REQ-029 data_req_i and tsmap_cs_i high for 3 cycles, tsmap_addr_i=7 -> gnt=0 for 3 cycles, sram_addr_o=7, tsmap_rdata_o valid each following cycle, stall_cnt_o=3; 4th cycle data granted.
REQ-030 Read 0x2010_0000 (out of range, MemAddrW=14) -> gnt=1, sram_cs_o=0, next cycle rvalid=1, err=1, rdata=0; cap write be=4'h7 -> err=1.
REQ-031 Four back-to-back reads addrs 0,4,8,12 -> four consecutive rvalid cycles, data in issue order; rstn_i pulsed low after 2nd grant -> no further rvalid.
REQ-032 Hold data_req_i and tsmap_cs_i for 70000 cycles -> stall_cnt_o stops at 16'hFFFF.
